// File: rtl/board_pkg.sv
// Shared definitions for the board-state memory scheduler: board geometry, cell codes,
// plot colours, RAM slot owners and the cell address helper.
package board_pkg;

    localparam logic [7:0] WIDTH  = 8'd160;
    localparam logic [6:0] HEIGHT = 7'd120;
    localparam int         AW     = 15;

    typedef enum logic [1:0] {
        CELL_P0 = 2'd0,
        CELL_P1 = 2'd1,
        CELL_P2 = 2'd2,
        CELL_PE = 2'd3
    } cell_e;

    localparam logic [5:0] P0_C = 6'b110100;
    localparam logic [5:0] P1_C = 6'b001010;
    localparam logic [5:0] P2_C = 6'b111011;
    localparam logic [5:0] PE_C = 6'b010101;

    typedef enum logic [1:0] {
        SLOT_CLR  = 2'd0,
        SLOT_GAME = 2'd1,
        SLOT_DRAW = 2'd2,
        SLOT_NONE = 2'd3
    } slot_e;

    function automatic logic [5:0] cell_colour(input logic [1:0] code);
        logic [5:0] colour;
        case (code)
            CELL_P0: colour = P0_C;
            CELL_P1: colour = P1_C;
            CELL_P2: colour = P2_C;
            default: colour = PE_C;
        endcase
        return colour;
    endfunction

    // y*160 + x built from two shifts so no multiplier is inferred.
    function automatic logic [AW-1:0] cell_addr(input logic [7:0] x, input logic [6:0] y);
        logic [AW-1:0] yw;
        yw = {8'd0, y};
        return (yw << 3'd7) + (yw << 3'd5) + {7'd0, x};
    endfunction

endpackage

// File: rtl/board_mem_sched_xy_scan_counter.sv
// Raster position counter with independent column/row registers; x advances fastest
// and the pair wraps from (X_LAST,Y_LAST) back to the origin.
module xy_scan_counter #(
    parameter int            XW     = 8,
    parameter int            YW     = 7,
    parameter logic [XW-1:0] X_LAST = '1,
    parameter logic [YW-1:0] Y_LAST = '1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    input  logic          clr,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;

    // Position register; clr wins over en so a restart always lands on the origin.
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            x_r <= '0;
            y_r <= '0;
        end else if (en) begin
            if (x_r == X_LAST) begin
                x_r <= '0;
                y_r <= (y_r == Y_LAST) ? '0 : y_r + 1'b1;
            end else begin
                x_r <= x_r + 1'b1;
            end
        end
    end

    assign x    = x_r;
    assign y    = y_r;
    assign last = (x_r == X_LAST) && (y_r == Y_LAST);

endmodule

// File: rtl/board_mem_sched.sv
// Single-port board RAM scheduler: one slot per cycle shared by the clear sweep,
// the game read/write port and the background VGA redraw scan.
module board_mem_sched
    import board_pkg::*;
(
    input  logic          CLOCK_50,
    input  logic          reset_n,
    input  logic          clear_start,
    output logic          clear_busy,
    input  logic          game_req,
    input  logic          game_we,
    input  logic [7:0]    game_x,
    input  logic [6:0]    game_y,
    input  logic [1:0]    game_wdata,
    output logic          game_gnt,
    output logic          game_rvalid,
    output logic [1:0]    game_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [1:0]    mem_wdata,
    input  logic [1:0]    mem_rdata,
    output logic [7:0]    vga_x,
    output logic [6:0]    vga_y,
    output logic [5:0]    vga_colour,
    output logic          vga_plot
);

    localparam logic [7:0] X_LAST = WIDTH - 8'd1;
    localparam logic [6:0] Y_LAST = HEIGHT - 7'd1;

    slot_e       slot_s;
    slot_e       owner_r;
    logic        clear_busy_r;
    logic        clear_go_s;
    logic        game_oob_s;
    logic        clr_en_s;
    logic        drw_en_s;
    logic        drw_wrap_s;
    logic [7:0]  clr_x_s;
    logic [6:0]  clr_y_s;
    logic        clr_last_s;
    logic [7:0]  drw_x_s;
    logic [6:0]  drw_y_s;
    logic        drw_last_s;
    logic [7:0]  plot_x_r;
    logic [6:0]  plot_y_r;
    logic        plot_r;
    logic        rd_r;
    logic        rd_oob_r;

    assign clear_go_s = clear_start & ~clear_busy_r;
    assign game_oob_s = (game_x >= WIDTH) | (game_y >= HEIGHT);
    assign clr_en_s   = (slot_s == SLOT_CLR);
    assign drw_en_s   = (slot_s == SLOT_DRAW);
    assign drw_wrap_s = drw_en_s & drw_last_s;

    xy_scan_counter #(.XW(8), .YW(7), .X_LAST(X_LAST), .Y_LAST(Y_LAST)) u_clear_scan (
        .clk     (CLOCK_50),
        .reset_n (reset_n),
        .en      (clr_en_s),
        .clr     (clear_go_s),
        .x       (clr_x_s),
        .y       (clr_y_s),
        .last    (clr_last_s)
    );

    xy_scan_counter #(.XW(8), .YW(7), .X_LAST(X_LAST), .Y_LAST(Y_LAST)) u_draw_scan (
        .clk     (CLOCK_50),
        .reset_n (reset_n),
        .en      (drw_en_s),
        .clr     (drw_wrap_s),
        .x       (drw_x_s),
        .y       (drw_y_s),
        .last    (drw_last_s)
    );

    // Fixed-priority slot owner; the game port also yields on the cycle a sweep is launched.
    always_comb begin
        slot_s = SLOT_NONE;
        if (!reset_n) begin
            slot_s = SLOT_NONE;
        end else if (clear_busy_r) begin
            slot_s = SLOT_CLR;
        end else if (game_req && !clear_start) begin
            slot_s = SLOT_GAME;
        end else begin
            slot_s = SLOT_DRAW;
        end
    end

    // RAM port and grant decode for the slot owner; off-board writes are dropped.
    always_comb begin
        mem_addr  = {AW{1'b0}};
        mem_we    = 1'b0;
        mem_wdata = 2'd0;
        game_gnt  = 1'b0;
        case (slot_s)
            SLOT_CLR: begin
                mem_addr  = cell_addr(clr_x_s, clr_y_s);
                mem_we    = 1'b1;
                mem_wdata = CELL_PE;
            end
            SLOT_GAME: begin
                game_gnt  = 1'b1;
                mem_addr  = cell_addr(game_x, game_y);
                mem_we    = game_we & ~game_oob_s;
                mem_wdata = game_wdata;
            end
            SLOT_DRAW: begin
                mem_addr  = cell_addr(drw_x_s, drw_y_s);
            end
            default: begin
                mem_addr  = {AW{1'b0}};
            end
        endcase
    end

    // Sweep busy flag: set by an accepted start, cleared after the final cell write.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            clear_busy_r <= 1'b0;
        end else if (clear_busy_r) begin
            clear_busy_r <= ~clr_last_s;
        end else begin
            clear_busy_r <= clear_start;
        end
    end

    // One-cycle slot pipeline lining up plot/read results with the RAM read latency.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            owner_r  <= SLOT_NONE;
            plot_r   <= 1'b0;
            plot_x_r <= 8'd0;
            plot_y_r <= 7'd0;
            rd_r     <= 1'b0;
            rd_oob_r <= 1'b0;
        end else begin
            owner_r  <= slot_s;
            plot_r   <= (slot_s == SLOT_CLR) || (slot_s == SLOT_DRAW);
            rd_r     <= (slot_s == SLOT_GAME) && !game_we;
            rd_oob_r <= game_oob_s;
            case (slot_s)
                SLOT_CLR: begin
                    plot_x_r <= clr_x_s;
                    plot_y_r <= clr_y_s;
                end
                SLOT_DRAW: begin
                    plot_x_r <= drw_x_s;
                    plot_y_r <= drw_y_s;
                end
                default: begin
                    plot_x_r <= plot_x_r;
                    plot_y_r <= plot_y_r;
                end
            endcase
        end
    end

    // Late-arriving RAM data is steered to the VGA colour or the game read port.
    always_comb begin
        vga_colour = 6'd0;
        game_rdata = 2'd0;
        if (owner_r == SLOT_CLR) begin
            vga_colour = PE_C;
        end else if (owner_r == SLOT_DRAW) begin
            vga_colour = cell_colour(mem_rdata);
        end else begin
            vga_colour = 6'd0;
        end
        if (rd_r) begin
            game_rdata = rd_oob_r ? CELL_PE : mem_rdata;
        end else begin
            game_rdata = 2'd0;
        end
    end

    assign clear_busy  = clear_busy_r;
    assign game_rvalid = rd_r;
    assign vga_plot    = plot_r;
    assign vga_x       = plot_x_r;
    assign vga_y       = plot_y_r;

endmodule
